ts_module_core: RTL and testbench

Programmable timebase generator: divides the system clock into periodic one-cycle tick pulses, counts those ticks in a wrapping timestamp counter, and optionally snapshots the timestamp on request. Sits at the top of the timing hierarchy; downstream blocks consume `tick` as their time unit and `ts_count` as the current time.

---
 rtl/ts_module_core.sv | 96 +++++++++
 tb/tb_ts_module_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_module_core.sv
// ts_module_core: programmable timebase generator.
// Divides clock into one-cycle tick pulses, counts ticks in a wrapping
// timestamp with a sticky overflow flag, and optionally snapshots the
// timestamp on request.
// Optional feature macro: TS_MODULE_CAPTURE_EN (capture logic present when
// defined; otherwise capture is ignored and cap_value/cap_valid read 0).
module ts_module_core #(
  parameter int CNT_W       = 32,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             capture,
  input  logic             clear_ovf,
  output logic             tick,
  output logic [CNT_W-1:0] ts_count,
  output logic             overflow,
  output logic [CNT_W-1:0] cap_value,
  output logic             cap_valid
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] pre_reg;
  logic [DIV_W-1:0] div_eff;
  logic             terminal;
  logic             advance;
  logic             wrap;

  // A programmed divider of zero behaves like a divide-by-one.
  assign div_eff  = (div_reg == '0) ? DIV_W'(1) : div_reg;
  assign terminal = (pre_reg == div_eff - DIV_W'(1));
  // A load restarts the period, so it masks a coinciding terminal count.
  assign advance  = enable && !div_load && terminal;
  assign wrap     = advance && (ts_count == {CNT_W{1'b1}});

  // Divider register, prescaler, tick pulse and timestamp counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_reg  <= DIV_W'(DEFAULT_DIV);
      pre_reg  <= '0;
      tick     <= 1'b0;
      ts_count <= '0;
    end else if (div_load) begin
      div_reg <= div_value;
      pre_reg <= '0;
      tick    <= 1'b0;
    end else if (enable) begin
      if (terminal) begin
        pre_reg  <= '0;
        tick     <= 1'b1;
        ts_count <= ts_count + CNT_W'(1);
      end else begin
        pre_reg <= pre_reg + DIV_W'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Sticky overflow: a wrap on the same edge as a clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wrap) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef TS_MODULE_CAPTURE_EN
  // Snapshot the timestamp as seen before this edge's increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_value <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= capture;
      if (capture) begin
        cap_value <= ts_count;
      end
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_value      = '0;
  assign cap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_ts_module_core.sv
// Self-checking bench for ts_module_core with a small timestamp width so
// wraps are reachable. Handles both builds of the capture feature
// (TS_MODULE_CAPTURE_EN).
module tb_ts_module_core;
  localparam int CNT_W = 6;
  localparam int DIV_W = 8;
  localparam int DEF_D = 10;
  localparam int MOD   = 1 << CNT_W;
`ifdef TS_MODULE_CAPTURE_EN
  localparam bit CAP_ON = 1'b1;
`else
  localparam bit CAP_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             capture = 1'b0;
  logic             clear_ovf = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] ts_count;
  logic             overflow;
  logic [CNT_W-1:0] cap_value;
  logic             cap_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tick when the number of enabled cycles since the last
  // restart is a multiple of the effective divider.
  int m_div, m_phase, m_ts, m_cap;
  bit m_tick, m_ovf, m_capv;

  ts_module_core #(.CNT_W(CNT_W), .DIV_W(DIV_W), .DEFAULT_DIV(DEF_D)) dut (
    .clock(clock), .reset(reset), .enable(enable), .div_load(div_load),
    .div_value(div_value), .capture(capture), .clear_ovf(clear_ovf),
    .tick(tick), .ts_count(ts_count), .overflow(overflow),
    .cap_value(cap_value), .cap_valid(cap_valid)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance one edge, update the model, settle.
  task automatic step(input bit r, input bit en, input bit ld, input int dv,
                      input bit cap, input bit clr);
    int  eff;
    bit  wrapped;
    reset = r; enable = en; div_load = ld; div_value = DIV_W'(dv);
    capture = cap; clear_ovf = clr;
    @(posedge clock);
    if (r) begin
      m_div = DEF_D; m_phase = 0; m_ts = 0; m_tick = 0; m_ovf = 0;
      m_cap = 0; m_capv = 0;
    end else begin
      wrapped = 0;
      if (CAP_ON) begin
        m_capv = cap;
        if (cap) m_cap = m_ts;
      end
      if (ld) begin
        m_div = dv; m_phase = 0; m_tick = 0;
      end else if (en) begin
        eff = (m_div == 0) ? 1 : m_div;
        m_phase = m_phase + 1;
        if (m_phase % eff == 0) begin
          m_tick = 1;
          wrapped = (m_ts + 1 == MOD);
          m_ts = (m_ts + 1) % MOD;
        end else begin
          m_tick = 0;
        end
      end else begin
        m_tick = 0;
      end
      if (wrapped) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 3, 1, 0);
    step(1, $urandom_range(0, 1), 1, 2, 1, 1);
    n_tests++;
    if ({tick, ts_count, overflow, cap_valid, cap_value} !== '0) begin
      n_fail++;
      $display("FAIL reset: tick=%0d ts=%0d ovf=%0d cv=%0d cap=%0d, required all 0",
               tick, ts_count, overflow, cap_valid, cap_value);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_default_period();
    for (int i = 1; i <= 100; i++) begin
      step(0, 1, 0, 0, 0, 0);
      n_tests++;
      if (tick !== ((i % 10) == 0) || ts_count !== CNT_W'(m_ts)) begin
        n_fail++;
        $display("FAIL default_period cyc %0d: tick=%0d ts=%0d, required tick=%0d ts=%0d",
                 i, tick, ts_count, (i % 10) == 0, m_ts);
      end
    end
    n_tests++;
    if (ts_count !== CNT_W'(10)) begin
      n_fail++;
      $display("FAIL default_period_final: ts=%0d, required 10", ts_count);
    end
    $display("[TB] default period: ts=%0d", ts_count);
  endtask

  task automatic test_div_zero();
    int ts0;
    step(0, 1, 1, 0, 0, 0);
    ts0 = m_ts;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      n_tests++;
      if (tick !== 1'b1 || ts_count !== CNT_W'(m_ts)) begin
        n_fail++;
        $display("FAIL div_zero cyc %0d: tick=%0d ts=%0d, required tick=1 ts=%0d",
                 i, tick, ts_count, m_ts);
      end
    end
    n_tests++;
    if (ts_count !== CNT_W'((ts0 + 5) % MOD)) begin
      n_fail++;
      $display("FAIL div_zero_adv: ts=%0d, required %0d", ts_count, (ts0 + 5) % MOD);
    end
    $display("[TB] div zero: ts=%0d", ts_count);
  endtask

  task automatic test_load_on_terminal();
    int ts0;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 0, 0);
    for (int i = 0; i < 10 && (m_phase % 5) != 4; i++) step(0, 1, 0, 0, 0, 0);
    ts0 = m_ts;
    step(0, 1, 1, 3, 0, 0);
    n_tests++;
    if (tick !== 1'b0 || ts_count !== CNT_W'(ts0)) begin
      n_fail++;
      $display("FAIL load_on_terminal: tick=%0d ts=%0d, required tick=0 ts=%0d",
               tick, ts_count, ts0);
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      n_tests++;
      if (tick !== (i == 3) || ts_count !== CNT_W'(m_ts)) begin
        n_fail++;
        $display("FAIL load_then_tick cyc %0d: tick=%0d ts=%0d, required tick=%0d ts=%0d",
                 i, tick, ts_count, i == 3, m_ts);
      end
    end
    $display("[TB] load on terminal: ts=%0d", ts_count);
  endtask

  task automatic test_wrap_overflow();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < MOD + 4 && m_ts != MOD - 1; i++) begin
      step(0, 1, 0, 0, 0, 0);
      n_tests++;
      if (overflow !== m_ovf || ts_count !== CNT_W'(m_ts)) begin
        n_fail++;
        $display("FAIL pre_wrap: ovf=%0d ts=%0d, required ovf=%0d ts=%0d",
                 overflow, ts_count, m_ovf, m_ts);
      end
    end
    step(0, 1, 0, 0, 0, 0);
    n_tests++;
    if (overflow !== 1'b1 || ts_count !== '0) begin
      n_fail++;
      $display("FAIL first_wrap: ovf=%0d ts=%0d, required ovf=1 ts=0", overflow, ts_count);
    end
    for (int i = 0; i < MOD + 4 && m_ts != MOD - 1; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    n_tests++;
    if (overflow !== 1'b1 || ts_count !== '0) begin
      n_fail++;
      $display("FAIL wrap_beats_clear: ovf=%0d ts=%0d, required ovf=1 ts=0", overflow, ts_count);
    end
    step(0, 0, 0, 0, 0, 1);
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ovf: ovf=%0d, required 0", overflow);
    end
    $display("[TB] wrap/overflow: ovf=%0d", overflow);
  endtask

  task automatic test_capture();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0);
    // Back-to-back captures while counting, then one idle cycle.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, i < 3, 0);
      n_tests++;
      if (cap_valid !== (CAP_ON && i < 3) || cap_value !== CNT_W'(m_cap)) begin
        n_fail++;
        $display("FAIL capture %0d: cv=%0d cap=%0d, required cv=%0d cap=%0d",
                 i, cap_valid, cap_value, CAP_ON && i < 3, m_cap);
      end
      if (i == 0) begin
        n_tests++;
        if (cap_value !== (CAP_ON ? CNT_W'(7) : CNT_W'(0))) begin
          n_fail++;
          $display("FAIL capture_seven: cap=%0d, required %0d", cap_value, CAP_ON ? 7 : 0);
        end
      end
    end
    $display("[TB] capture: cap=%0d", cap_value);
  endtask

  task automatic test_enable_hold();
    int ts0;
    int wait_n;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    ts0 = m_ts;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (tick !== 1'b0 || ts_count !== CNT_W'(ts0)) begin
        n_fail++;
        $display("FAIL hold cyc %0d: tick=%0d ts=%0d, required tick=0 ts=%0d",
                 i, tick, ts_count, ts0);
      end
    end
    wait_n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, 0);
      wait_n++;
      if (tick === 1'b1) break;
    end
    n_tests++;
    if (wait_n != 5 || ts_count !== CNT_W'(ts0 + 1)) begin
      n_fail++;
      $display("FAIL hold_resume: tick after %0d cycles ts=%0d, required 5 cycles ts=%0d",
               wait_n, ts_count, ts0 + 1);
    end
    $display("[TB] enable hold: tick after %0d resumed cycles", wait_n);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 4),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      n_tests++;
      if ({tick, ts_count, overflow, cap_valid, cap_value} !==
          {m_tick, CNT_W'(m_ts), m_ovf, m_capv, CNT_W'(m_cap)}) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc %0d: t/ts/o/cv/cap=%0d/%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d/%0d",
                   i, tick, ts_count, overflow, cap_valid, cap_value,
                   m_tick, m_ts, m_ovf, m_capv, m_cap);
      end
    end
    $display("[TB] random: 1500 cycles, %0d mismatching", errs);
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_div_zero();
    test_load_on_terminal();
    test_wrap_overflow();
    test_capture();
    test_enable_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
